instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage sitting directly upstream of the control unit in the single-issue 3-bit-opcode CPU. Issues requests to instruction memory over a req/ack handshake, holds the returned 16-bit instruction in an instruction register, and presents `opcode` (bits [15:13]) to the control unit alongside the full instruction and its PC. Handles back-pressure from the downstream stage (`stall`) and taken-branch redirects, discarding wrong-path data.

## Interface
- `PC_W`, 8, PC and instruction-memory address width (word addressed)
- `INSTR_W`, 16, instruction width; opcode is always the top 3 bits
- `RESET_PC`, 0, first fetch address after reset
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `imem_req`  out  1  fetch request, held until `imem_ack`
- `imem_addr`  out  PC_W  fetch address, stable while `imem_req`=1
- `imem_ack`  in  1  single-cycle response strobe; may coincide with first cycle of `imem_req`
- `imem_rdata`  in  INSTR_W  instruction data, valid only when `imem_ack`=1
- `stall`  in  1  downstream not ready to consume current instruction
- `branch_taken`  in  1  single-cycle redirect pulse
- `branch_target`  in  PC_W  redirect address, valid with `branch_taken`
- `instr_valid`  out  1  instruction register holds a valid instruction
- `instr`  out  INSTR_W  instruction register
- `opcode`  out  3  `instr[INSTR_W-1:INSTR_W-3]`, feeds control unit
- `pc_out`  out  PC_W  address of the instruction in `instr`

## Operation
- Registers: `fetch_pc` (drives `imem_addr`), `redirect_pc`, instruction register, `pc_out`, state.
- States: IDLE, FETCH, HOLD, FLUSH. `imem_req` = 1 in FETCH and FLUSH only. `instr_valid` = 1 in HOLD only.
- IDLE: entered by reset; next cycle -> FETCH.
- FETCH: on `imem_ack` latch `imem_rdata` into `instr`, `pc_out`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+1 (modulo 2^PC_W, wraps to 0), -> HOLD.
- HOLD: if `stall`=0, instruction consumed at that edge, -> FETCH. If `stall`=1, stay; `instr`/`pc_out` unchanged.
- FLUSH: wrong-path request outstanding; `imem_addr` unchanged. On `imem_ack` discard data, `fetch_pc`<=`redirect_pc`, -> FETCH.
- `branch_taken` has priority over `stall` and over normal ack handling:
  - IDLE or HOLD: `fetch_pc`<=`branch_target`, -> FETCH (held instruction dropped).
  - FETCH with `imem_ack`=1: discard data, `fetch_pc`<=`branch_target`, -> FETCH.
  - FETCH with `imem_ack`=0: `redirect_pc`<=`branch_target`, -> FLUSH.
  - FLUSH with `imem_ack`=0: `redirect_pc`<=`branch_target` (latest wins), stay.
  - FLUSH with `imem_ack`=1: discard, `fetch_pc`<=`branch_target`, -> FETCH.
- `imem_ack` outside FETCH/FLUSH is ignored.

## Timing
- Reset values: state IDLE, `fetch_pc`=RESET_PC, `redirect_pc`=0, `instr`=0, `pc_out`=0, `imem_req`=0, `instr_valid`=0, `opcode`=0.
- `rst` overrides everything, including mid-request; the outstanding request is abandoned, no flush.
- First `imem_req` in the 2nd cycle after `rst` deasserts.
- Latency: ack at edge t -> `instr_valid`=1 from cycle t+1.
- Zero-wait memory, no stall: one instruction per 2 cycles (FETCH, HOLD alternating).
- Branch sampled at edge t -> `instr_valid`=0 from t+1; request to target starts cycle t+1 (or cycle after FLUSH ack).

## Configuration
- `FETCH_PERF_EN`: when defined, adds outputs `perf_fetched` (16 bits, increments per instruction consumed in HOLD with `stall`=0) and `perf_stall` (16 bits, increments each HOLD cycle with `stall`=1); both saturate at 0xFFFF, reset to 0. When undefined, ports and counters absent; all other behaviour identical.

## Test plan
- Reset then zero-wait memory returning `mem[a]`, `stall`=0: `imem_addr` sequence 0,1,2,3; `instr_valid` pulses every 2nd cycle; `pc_out` 0,1,2,3; `opcode` = top 3 bits of each word.
- `stall`=1 for 5 cycles with instruction 0x8123 at PC 4 held: `instr`=0x8123, `opcode`=3'b100, `pc_out`=4 stable; no `imem_req`; resumes with address 5.
- Memory with 3-cycle ack latency, `branch_taken` to 0x40 in 1st wait cycle: `imem_addr` stays at old value until ack, data discarded (`instr_valid` stays 0), next request addr 0x40.
- Branch to 0x10 in HOLD with `stall`=1 simultaneously: `instr_valid`=0 next cycle, next `imem_addr`=0x10.
- `fetch_pc`=0xFF fetch completes: next `imem_addr`=0x00.
- `rst` asserted while FLUSH outstanding: all outputs return to reset values next cycle; first fetch after release at RESET_PC; with `FETCH_PERF_EN`, counters read 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with req/ack memory port, stall and branch redirect; FETCH_PERF_EN adds perf counters
module instr_fetch_unit #(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic [PC_W-1:0]    pc_out
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_stall
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;

  state_t          state;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] redirect_pc;

  assign imem_addr = fetch_pc;
  assign opcode    = instr[INSTR_W-1 -: 3];

  // Fetch FSM; imem_req/instr_valid are registered alongside the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= PC_W'(RESET_PC);
      redirect_pc <= '0;
      instr       <= '0;
      pc_out      <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (branch_taken) fetch_pc <= branch_target;
          state       <= FETCH;
          imem_req    <= 1'b1;
          instr_valid <= 1'b0;
        end
        FETCH: begin
          if (branch_taken && imem_ack) begin
            // wrong-path data arrived together with the redirect: drop it and refetch
            fetch_pc <= branch_target;
          end else if (branch_taken) begin
            // request still outstanding; it must complete before redirecting
            redirect_pc <= branch_target;
            state       <= FLUSH;
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            pc_out      <= fetch_pc;
            fetch_pc    <= fetch_pc + PC_W'(1);
            state       <= HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (branch_taken || !stall) begin
            if (branch_taken) fetch_pc <= branch_target;
            state       <= FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        FLUSH: begin
          if (imem_ack) begin
            fetch_pc <= branch_taken ? branch_target : redirect_pc;
            state    <= FETCH;
          end else if (branch_taken) begin
            redirect_pc <= branch_target;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters of consumed instructions and stalled hold cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else if (state == HOLD) begin
      if (!stall && !branch_taken && perf_fetched != 16'hFFFF)
        perf_fetched <= perf_fetched + 16'd1;
      if (stall && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit with memory responder and stream model
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        instr_valid;
  logic [15:0] instr;
  logic [2:0]  opcode;
  logic [7:0]  pc_out;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall;
`endif

  instr_fetch_unit #(.PC_W(8), .INSTR_W(16), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .pc_out(pc_out)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] mem [256];
  int lat = 0;
  int wcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: acks each request after 'lat' wait cycles with mem[addr]
  initial begin
    forever begin
      @(negedge clk);
      if (imem_req && !rst) begin
        if (wcnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          wcnt       = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 16'hDEAD;
          wcnt++;
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        wcnt       = 0;
      end
    end
  end

  // Fetch-stream model: what is held for the consumer, what is being asked for,
  // and whether the outstanding request has already been made obsolete by a branch
  logic        m_start, m_req, m_valid, m_wrong;
  logic [7:0]  m_addr, m_redir, m_pc;
  logic [15:0] m_instr;

  task automatic model_step();
    if (rst) begin
      m_start = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_wrong = 1'b0;
      m_addr = 8'h00; m_redir = 8'h00; m_pc = 8'h00; m_instr = 16'h0;
    end else if (m_start) begin
      m_start = 1'b0;
      m_req   = 1'b1;
      if (branch_taken) m_addr = branch_target;
    end else if (m_valid) begin
      if (branch_taken) begin
        m_valid = 1'b0; m_req = 1'b1; m_addr = branch_target;
      end else if (!stall) begin
        m_valid = 1'b0; m_req = 1'b1;
      end
    end else if (m_req) begin
      if (imem_ack) begin
        if (branch_taken) m_addr = branch_target;
        else if (m_wrong) m_addr = m_redir;
        else begin
          m_valid = 1'b1; m_req = 1'b0;
          m_instr = imem_rdata; m_pc = m_addr; m_addr = m_addr + 8'd1;
        end
        m_wrong = 1'b0;
      end else if (branch_taken) begin
        m_wrong = 1'b1; m_redir = branch_target;
      end
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model, just after each edge
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("req", imem_req, m_req);
      check("valid", instr_valid, m_valid);
      check("instr", instr, m_instr);
      check("pc_out", pc_out, m_pc);
      check("opcode", opcode, m_instr[15:13]);
      if (m_req) check("addr", imem_addr, m_addr);
    end
  end

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 40);
    if (!instr_valid) check("valid_timeout", instr_valid, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0731 + 16'h1234);
    mem[0] = 16'h2000; mem[1] = 16'h4011; mem[2] = 16'h6022; mem[3] = 16'hE033;
    mem[4] = 16'h8123; mem[5] = 16'hA055; mem[8'h40] = 16'hC040; mem[8'h10] = 16'h1010;
    mem[8'hFE] = 16'h3FFE; mem[8'hFF] = 16'h5FFF;

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", pc_out, 0);
    check("rst_opcode", opcode, 0);

    // Zero-wait streaming
    wait_valid(); check("s_pc0", pc_out, 8'h00); check("s_op0", opcode, 3'b001);
    wait_valid(); check("s_pc1", pc_out, 8'h01); check("s_op1", opcode, 3'b010);
    wait_valid(); check("s_pc2", pc_out, 8'h02); check("s_op2", opcode, 3'b011);
    wait_valid(); check("s_pc3", pc_out, 8'h03); check("s_op3", opcode, 3'b111);

    // Stall five cycles on PC 4
    wait_valid();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("st_instr", instr, 16'h8123);
      check("st_opcode", opcode, 3'b100);
      check("st_pc", pc_out, 8'h04);
      check("st_req", imem_req, 0);
    end
    stall = 1'b0;
    wait_valid(); check("st_resume_pc", pc_out, 8'h05);

    // Slow memory, branch during the first wait cycle
    lat = 3;
    @(negedge clk);
    check("fl_addr0", imem_addr, 8'h06);
    branch_taken = 1'b1; branch_target = 8'h40;
    @(negedge clk);
    branch_taken = 1'b0;
    check("fl_addr1", imem_addr, 8'h06);
    check("fl_valid", instr_valid, 0);
    wait_valid(); check("fl_pc", pc_out, 8'h40); check("fl_instr", instr, 16'hC040);

    // Branch in HOLD while stalled
    stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h10;
    @(negedge clk);
    stall = 1'b0; branch_taken = 1'b0; lat = 0;
    check("bh_valid", instr_valid, 0);
    check("bh_addr", imem_addr, 8'h10);
    wait_valid(); check("bh_pc", pc_out, 8'h10);

    // PC wrap-around
    branch_taken = 1'b1; branch_target = 8'hFE;
    @(negedge clk);
    branch_taken = 1'b0;
    wait_valid(); check("w_pcfe", pc_out, 8'hFE);
    wait_valid(); check("w_pcff", pc_out, 8'hFF);
    @(negedge clk);
    check("w_addr0", imem_addr, 8'h00);
    check("w_req", imem_req, 1);
    wait_valid(); check("w_pc0", pc_out, 8'h00);

    // Directed mix of stalls, back-to-back branches and latencies
    for (int i = 0; i < 40; i++) begin
      lat           = i % 3;
      stall         = ((i % 5) == 1) || ((i % 7) == 3);
      branch_taken  = ((i % 6) == 2) || (i == 15);
      branch_target = 8'(i * 37 + 5);
      @(negedge clk);
    end
    stall = 1'b0; branch_taken = 1'b0;

    // Reset while a flush is outstanding
    lat = 3;
    wait_valid();
    @(negedge clk);
    check("rf_req", imem_req, 1);
    branch_taken = 1'b1; branch_target = 8'h22;
    @(negedge clk);
    branch_taken = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rf_req0", imem_req, 0);
    check("rf_valid0", instr_valid, 0);
    check("rf_instr0", instr, 0);
    check("rf_pc0", pc_out, 0);
    check("rf_op0", opcode, 0);
`ifdef FETCH_PERF_EN
    check("rf_perf_f", perf_fetched, 0);
    check("rf_perf_s", perf_stall, 0);
`endif
    @(negedge clk);
    check("rf_first_req", imem_req, 1);
    check("rf_first_addr", imem_addr, 8'h00);
    wait_valid(); check("rf_pc", pc_out, 8'h00);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
